serial_add_seq: RTL and testbench

//  Bit-serial operand sequencer for the 1-bit full_adder slice. Accepts

---
 rtl/serial_add_pkg.sv | 8 +
 rtl/sa_shift_reg.sv | 25 ++
 rtl/serial_add_seq.sv | 112 +++++++++++
 tb/tb_serial_add_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and defaults for the bit-serial adder sequencer
package serial_add_pkg;

  typedef enum logic [1:0] {SA_IDLE, SA_RUN, SA_DONE} sa_state_t;

  localparam int SA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sa_shift_reg.sv
// rtl/sa_shift_reg.sv - parallel-load, shift-right register with serial input at the MSB
module sa_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  // Load wins over shift so an accept always starts from clean operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {ser_in, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - LSB-first operand sequencer for an external full_adder; SERIAL_ADD_SUB_EN adds in_sub
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             fa_a0,
  output logic             fa_b0,
  output logic             fa_c0,
  input  logic             fa_s_out,
  input  logic             fa_c_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  // WIDTH-1 always fits in CNT_W bits, so this compare never sees a wrapped value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             accept, run, done;
  logic [WIDTH-1:0] a_q, b_q, sum_q, b_load;
  logic             carry_load;
  logic             unused_upper;

`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = in_sub ? ~in_b : in_b;
  assign carry_load = in_sub ? 1'b1  : in_cin;
`else
  assign b_load     = in_b;
  assign carry_load = in_cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SA_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SA_IDLE: if (in_valid)         state_nxt = SA_RUN;
      SA_RUN:  if (cnt == CNT_LAST)  state_nxt = SA_DONE;
      SA_DONE: if (out_ready)        state_nxt = SA_IDLE;
      default:                       state_nxt = SA_IDLE;
    endcase
  end

  assign accept = (state == SA_IDLE) && in_valid;
  assign run    = (state == SA_RUN);
  assign done   = (state == SA_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      carry_q <= carry_load;
    end else if (run) begin
      cnt     <= cnt + CNT_W'(1);
      carry_q <= fa_c_out;
    end
  end

  sa_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(in_a),
    .shift(run), .ser_in(1'b0), .q(a_q)
  );

  sa_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(b_load),
    .shift(run), .ser_in(1'b0), .q(b_q)
  );

  sa_shift_reg #(.WIDTH(WIDTH)) u_sum_sh (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data('0),
    .shift(run), .ser_in(fa_s_out), .q(sum_q)
  );

  // Only the LSBs of the operand registers reach the adder.
  assign unused_upper = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

  assign fa_a0     = run & a_q[0];
  assign fa_b0     = run & b_q[0];
  assign fa_c0     = run & carry_q;

  assign in_ready  = (state == SA_IDLE);
  assign busy      = run | done;
  assign out_valid = done;
  assign out_sum   = done ? sum_q : '0;
  assign out_cout  = done & carry_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - self-checking bench for serial_add_seq with a behavioural full_adder
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         fa_a0, fa_b0, fa_c0, fa_s_out, fa_c_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 1-bit full_adder slice the parent would normally supply.
  assign fa_s_out = fa_a0 ^ fa_b0 ^ fa_c0;
  assign fa_c_out = (fa_a0 & fa_b0) | (fa_a0 & fa_c0) | (fa_b0 & fa_c0);

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub(in_sub),
`endif
    .fa_a0(fa_a0), .fa_b0(fa_b0), .fa_c0(fa_c0),
    .fa_s_out(fa_s_out), .fa_c_out(fa_c_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair, measure latency, check the result and complete the handshake.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int wait_cyc = 0;
    int lat = 0;
    while (!in_ready && wait_cyc < 50) begin
      tick();
      wait_cyc++;
    end
    check({name, " in_ready"}, in_ready, 1'b1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, W);
    check({name, " sum"}, out_sum, exp_sum);
    check({name, " cout"}, out_cout, exp_cout);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " valid drop"}, out_valid, 1'b0);
    check({name, " sum zero"}, out_sum, '0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [W:0]   ref_full;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           lat;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    #2;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset fa", {fa_a0, fa_b0, fa_c0}, 3'b000);
    check("reset out_sum", out_sum, '0);
    check("reset out_cout", out_cout, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
             vecs[i].exp_sum, vecs[i].exp_cout);
    end

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op($sformatf("rand%0d", i), ra, rb, rc, 1'b0, ref_full[W-1:0], ref_full[W]);
    end

    // Consumer stalls in DONE; a stray in_valid pulse must be ignored.
    in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("stall latency", lat, W);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_a = 8'hEE; in_b = 8'hEE;
      check("stall valid", out_valid, 1'b1);
      check("stall sum", out_sum, 8'h46);
      check("stall cout", out_cout, 1'b0);
      check("stall in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall release in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall no queued op", busy | out_valid, 1'b0);
    end

    // Reset after three RUN bits discards the operation.
    in_a = 8'h55; in_b = 8'hAA; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrun rst busy", busy, 1'b0);
    check("midrun rst in_ready", in_ready, 1'b1);
    check("midrun rst fa", {fa_a0, fa_b0, fa_c0}, 3'b000);
    check("midrun rst out", {out_valid, out_cout, out_sum}, '0);
    rst_n = 1'b1;
    tick();
    run_op("post reset", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

    // Back-to-back: in_valid and out_ready held high throughout.
    in_a = 8'h03; in_b = 8'h04; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_a = 8'h05; in_b = 8'h06;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("b2b first latency", lat, W);
    check("b2b first sum", out_sum, 8'h07);
    tick();
    check("b2b handshake in_ready", in_ready, 1'b1);
    check("b2b handshake busy", busy, 1'b0);
    tick();
    check("b2b second accept", busy, 1'b1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("b2b second latency", lat, W);
    check("b2b second sum", out_sum, 8'h0B);
    tick();
    out_ready = 1'b0;
    check("b2b done", out_valid, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub 10-01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub 00-01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ref_full = {1'b0, ra} - {1'b0, rb};
      run_op($sformatf("rsub%0d", i), ra, rb, 1'($urandom), 1'b1, ref_full[W-1:0], ~ref_full[W]);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
